// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, frame bit levels, parity
// convention and the default word width used by the TX and RX paths.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Parity bit from the XOR-reduction of the data: even parity is the
  // reduction itself, odd parity is its inverse.
  function automatic logic calc_parity(input logic data_xor, input logic par_type);
    return data_xor ^ (par_type == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for the UART transmitter. The FSM
// loads a word on acceptance and shifts once per data bit; last_bit tells
// it the final data bit is on the line.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  cur_bit,
  output logic                  nxt_bit,
  output logic                  last_bit
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] sreg_q, sreg_d, sreg_nxt;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Bit 0 of the register is always the bit currently being sent; the
  // FSM registers the line, so it also needs the bit that follows a shift.
  assign sreg_nxt = sreg_q >> 1;
  assign cur_bit  = sreg_q[0];
  assign nxt_bit  = sreg_nxt[0];
  assign last_bit = (cnt_q == CW'(DATA_WIDTH - 1));

  // Load wins over shift; the counter returns to 0 when the last bit leaves.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load) begin
      sreg_d = data_in;
      cnt_d  = '0;
    end else if (shift) begin
      sreg_d = sreg_nxt;
      cnt_d  = last_bit ? '0 : cnt_q + CW'(1);
    end
  end

  // Register state; async clear abandons any word in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB-first, optional
// parity bit, one stop bit. One CLK period is one bit time. TX_OUT and
// Busy come straight from flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  Parity_Enable,
  input  logic                  Parity_Type,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e state_q, state_d;
  logic      tx_out_q, tx_out_d;
  logic      busy_q, busy_d;
  logic      par_en_q, par_en_d;
  logic      par_bit_q, par_bit_d;
  logic      load, shift;
  logic      cur_bit, nxt_bit, last_bit;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .shift    (shift),
    .data_in  (P_DATA),
    .cur_bit  (cur_bit),
    .nxt_bit  (nxt_bit),
    .last_bit (last_bit)
  );

  // Next-state and next-output logic. The line value is computed for the
  // state being entered, so the registered TX_OUT lines up with the state.
  always_comb begin
    state_d   = state_q;
    tx_out_d  = tx_out_q;
    busy_d    = busy_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_out_d = STOP_BIT;
        busy_d   = 1'b0;
        if (Data_Valid) begin
          load      = 1'b1;
          par_en_d  = Parity_Enable;
          par_bit_d = calc_parity(^P_DATA, Parity_Type);
          state_d   = START;
          tx_out_d  = START_BIT;
          busy_d    = 1'b1;
        end
      end
      START: begin
        state_d  = DATA;
        tx_out_d = cur_bit;
        busy_d   = 1'b1;
      end
      DATA: begin
        shift  = 1'b1;
        busy_d = 1'b1;
        if (!last_bit) begin
          tx_out_d = nxt_bit;
        end else if (par_en_q) begin
          state_d  = PARITY;
          tx_out_d = par_bit_q;
        end else begin
          state_d  = STOP;
          tx_out_d = STOP_BIT;
        end
      end
      PARITY: begin
        state_d  = STOP;
        tx_out_d = STOP_BIT;
        busy_d   = 1'b1;
      end
      STOP: begin
        state_d  = IDLE;
        tx_out_d = STOP_BIT;
        busy_d   = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = STOP_BIT;
        busy_d   = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs; reset drives the line idle at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      tx_out_q  <= STOP_BIT;
      busy_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  assign TX_OUT = tx_out_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes whole expected frames,
// the monitor captures each Busy window and compares it bit by bit.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       Parity_Enable = 1'b0;
  logic       Parity_Type = 1'b0;
  logic       TX_OUT;
  logic       Busy;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .P_DATA        (P_DATA),
    .Data_Valid    (Data_Valid),
    .Parity_Enable (Parity_Enable),
    .Parity_Type   (Parity_Type),
    .TX_OUT        (TX_OUT),
    .Busy          (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] bits;
    logic [4:0]  len;
    logic        gap1;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   to_cnt = 0;
  bit   end_req = 1'b0;

  // Reference frame: start 0, data LSB-first, parity if enabled, stop 1.
  function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic pt,
                              input logic g);
    exp_t e;
    int   n;
    e.bits = '0;
    e.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) e.bits[1+i] = d[i];
    n = 9;
    if (pe) begin
      e.bits[n] = ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ pt;
      n++;
    end
    e.bits[n] = 1'b1;
    n++;
    e.len  = 5'(n);
    e.gap1 = g;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, and checks the async reset a
  // moment after RST falls.
  int          cyc = 0;
  int          last_end = -100;
  int          idx = 0;
  logic [15:0] got = '0;
  bit          active = 1'b0;
  bit          post = 1'b0;
  bit          busy_ok = 1'b1;
  bit          rst_seen_hi = 1'b0;
  bit          end_done = 1'b0;
  exp_t        cur = '0;

  always @(negedge CLK or negedge RST) begin
    if (!RST) begin
      if (rst_seen_hi) begin
        rst_seen_hi = 1'b0;
        #1;
        chk("async_rst", {30'd0, TX_OUT, Busy}, 32'h2);
      end else begin
        chk("rst_state", {30'd0, TX_OUT, Busy}, 32'h2);
      end
      sb.delete();
      active = 1'b0;
      post   = 1'b0;
    end else begin
      rst_seen_hi = 1'b1;
      cyc++;
      if (!active && Busy === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          if (cur.gap1) chk("b2b_gap", 32'(cyc - last_end), 32'd2);
          got     = '0;
          idx     = 0;
          busy_ok = 1'b1;
          active  = 1'b1;
        end
        post = 1'b0;
      end
      if (active) begin
        got[idx] = TX_OUT;
        if (Busy !== 1'b1) busy_ok = 1'b0;
        idx++;
        if (idx == int'(cur.len)) begin
          chk("frame_bits", {16'd0, got}, {16'd0, cur.bits});
          chk("busy_len", {31'd0, busy_ok}, 32'd1);
          active   = 1'b0;
          post     = 1'b1;
          last_end = cyc;
        end
      end else if (Busy !== 1'b1) begin
        if (post) chk("idle_after", {30'd0, Busy, TX_OUT}, 32'h1);
        else      chk("idle_line", {31'd0, TX_OUT}, 32'h1);
        post = 1'b0;
      end
      if (end_req && !end_done) begin
        end_done = 1'b1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("timeouts", 32'(to_cnt), 32'd0);
        chk("in_frame", {31'd0, active}, 32'd0);
      end
    end
  end

  task automatic scramble();
    P_DATA        = 8'($urandom);
    Parity_Enable = 1'($urandom);
    Parity_Type   = 1'($urandom);
  endtask

  // One-cycle Data_Valid once the transmitter is idle.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt);
    int w = 0;
    @(posedge CLK); #2;
    while (Busy !== 1'b0 && w < 40) begin
      @(posedge CLK); #2;
      w++;
    end
    if (w >= 40) to_cnt++;
    P_DATA = d; Parity_Enable = pe; Parity_Type = pt; Data_Valid = 1'b1;
    sb.push_back(mk(d, pe, pt, 1'b0));
    @(posedge CLK); #2;
    Data_Valid = 1'b0;
    scramble();
  endtask

  task automatic pulse_after(input int k);
    repeat (k) @(posedge CLK);
    #2;
    scramble();
    Data_Valid = 1'b1;
    @(posedge CLK); #2;
    Data_Valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;

    send(8'hA5, 1'b1, 1'b0);
    send(8'h00, 1'b1, 1'b1);
    send(8'hFF, 1'b0, 1'b0);

    // Held Data_Valid: two frames one idle cycle apart, inputs churn mid-frame.
    @(posedge CLK); #2;
    while (Busy !== 1'b0) begin @(posedge CLK); #2; end
    P_DATA = 8'h3C; Parity_Enable = 1'b0; Parity_Type = 1'b0; Data_Valid = 1'b1;
    sb.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b1));
    for (int i = 1; i <= 12; i++) begin
      @(posedge CLK); #2;
      if (i <= 6) scramble();
      else begin
        P_DATA = 8'hC3; Parity_Enable = 1'b0; Parity_Type = 1'($urandom);
      end
    end
    Data_Valid = 1'b0;
    scramble();

    // Valid pulse inside a frame is dropped.
    send(8'h69, 1'b1, 1'b1);
    pulse_after(3);

    // Reset during data bit 3 of 0x55, then a clean frame.
    send(8'h55, 1'b0, 1'b0);
    repeat (4) @(posedge CLK);
    #2 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    repeat (2) @(posedge CLK);
    send(8'h96, 1'b1, 1'b0);

    // Random traffic with random gaps and stray mid-frame pulses.
    for (int n = 0; n < 24; n++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) pulse_after($urandom_range(1, 6));
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end

    repeat (16) @(posedge CLK);
    end_req = 1'b1;
    repeat (3) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
